eeprom_access_arbiter: RTL
==========================

# eeprom_access_arbiter

Two-client arbiter and sequencer in front of the EEPROM byte-transaction engine (I2C start/address/data/stop sequencer for an AT24C02-class device). Grants the engine to one client at a time with round-robin priority, retries NACKed transactions, and enforces the EEPROM internal write-cycle time before any further access. Sits between application logic (e.g. a parameter store and a display/readback path) and the single I2C master.

## Interface
- `WR_GAP_CYC`, default 60000: clk cycles of enforced idle after a successful write (5 ms at 12 MHz).
- `MAX_RETRY`, default 3: NACK re-issues allowed before the transaction fails.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 2: per-client request, level, held until that client's `done`.
- `we` in 2: per-client 1 = write, 0 = read; stable while `req`.
- `addr` in 16: client n word address in `[8n+7:8n]`.
- `wdata` in 16: client n write byte in `[8n+7:8n]`.
- `done` out 2: one-cycle completion pulse, per client.
- `err` out 1: valid with `done`; 1 = retries exhausted.
- `rdata` out 8: read byte, valid with `done` for a read.
- `busy` out 1: high in any state other than IDLE.
- `cmd_valid` out 1: command to engine.
- `cmd_ready` in 1: engine accepts command.
- `cmd_we`, `cmd_addr[7:0]`, `cmd_wdata[7:0]` out: command fields, stable while `cmd_valid`.
- `rsp_valid` in 1: engine completion pulse.
- `rsp_nack` in 1: with `rsp_valid`, any byte NACKed.
- `rsp_rdata` in 8: with `rsp_valid`, read byte.

## Operation
- States: IDLE, ISSUE, WAIT_RSP, GAP.
- IDLE: if any `req`, select winner; latch `owner`, `we`, `addr`, `wdata`; clear `retry_cnt`; go ISSUE.
- Round-robin: pointer `last`; the client not equal to `last` wins on conflict; single requester always wins. Reset `last` = 1, so client 0 wins the first conflict. `last` updates on grant.
- ISSUE: `cmd_valid` = 1 with latched fields; on `cmd_ready` go WAIT_RSP.
- WAIT_RSP: wait for `rsp_valid`.
  - Ack, read: `rdata` <= `rsp_rdata`, pulse `done[owner]`, `err` = 0, go IDLE.
  - Ack, write: pulse `done[owner]`, `err` = 0, load gap counter, go GAP.
  - NACK with `retry_cnt` < `MAX_RETRY`: increment, go ISSUE. The command is identical.
  - NACK with `retry_cnt` == `MAX_RETRY`: pulse `done[owner]` with `err` = 1, go IDLE. No gap.
- GAP: count down `WR_GAP_CYC`, ignore `req`, then go IDLE. The counter is at least 17 bits and saturates at 0.
- `req` deasserted mid-transaction: ignored; the transaction completes and `done` still pulses.
- `rsp_valid` outside WAIT_RSP: ignored.

## Timing
- Reset values: `done` = 0, `err` = 0, `rdata` = 0, `busy` = 0, `cmd_valid` = 0, `cmd_we`/`cmd_addr`/`cmd_wdata` = 0, state IDLE, `last` = 1.
- Reset mid-transaction clears `cmd_valid` immediately. The engine must share `rst`.
- `req` seen in IDLE at edge k: `cmd_valid` high from k+1.
- `rsp_valid` at edge m: `done`, `err` and `rdata` are registered and high in cycle m+1 only.
- Write: earliest next `cmd_valid` is `WR_GAP_CYC` + 2 cycles after `rsp_valid`.
- NACK retry: `cmd_valid` high again 1 cycle after the NACK `rsp_valid`.
- `done` never pulses for both clients in the same cycle. At most one transaction is outstanding.

## Structure
- Shared package `eeprom_pkg`: state enum, default `WR_GAP_CYC`/`MAX_RETRY`, and client count 2. The driver later reuses the 8-bit address/data width constants from it.
- One sub-module: `rr_arb2`, a two-requester round-robin picker with registered `last` and an update strobe. Everything else stays flat.

## Test plan
1. Client 0 reads addr 0x80; engine returns 0xFE, ack → `cmd_addr` = 0x80, `cmd_we` = 0; `done` = 2'b01 one cycle; `rdata` = 0xFE; `err` = 0.
2. Client 1 writes 0x5A to 0x10, with `WR_GAP_CYC` = 20 → `done` = 2'b10; client 0 req held; next `cmd_valid` exactly 22 cycles after `rsp_valid`.
3. Both clients request continuously, reads only → grant order 0,1,0,1; each `done` matches the latched `addr`.
4. Engine NACKs 3 times, then acks a read returning 0x33 → 4 `cmd_valid` handshakes; single `done`, `err` = 0, `rdata` = 0x33.
5. Engine NACKs 4 times → 4 handshakes; `done` with `err` = 1; no GAP; IDLE next cycle.
6. Assert `rst` during WAIT_RSP, then release with client 1 requesting → `cmd_valid` low asynchronously; no `done`; client 1 served, with `busy` = 0 during reset.

Source files
------------

// File: rtl/eeprom_pkg.sv
// Shared types and constants for the EEPROM access path.
// Used by the arbiter now and by the byte engine driver later.
package eeprom_pkg;

  localparam int N_CLIENTS      = 2;
  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 8;
  localparam int WR_GAP_CYC_DEF = 60000;
  localparam int MAX_RETRY_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_GAP
  } arb_state_e;

  // Gap counter never narrower than 17 bits.
  function automatic int gap_cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w > 17) ? w : 17;
  endfunction

endpackage

// File: rtl/eeprom_access_arbiter_rr_arb2.sv
// Two-requester round-robin picker.
// The requester other than the last winner wins a conflict.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       gnt_idx
);

  logic last;

  always_comb begin
    gnt_idx = req[1];
    if (req == 2'b11)
      gnt_idx = ~last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (upd && |req)
      last <= gnt_idx;
  end

endmodule

// File: rtl/eeprom_access_arbiter.sv
// Two-client arbiter/sequencer in front of the EEPROM byte engine.
// Retries NACKs and enforces the post-write internal cycle time.
module eeprom_access_arbiter
  import eeprom_pkg::*;
#(
  parameter int WR_GAP_CYC = WR_GAP_CYC_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CLIENTS-1:0] req,
  input  logic [N_CLIENTS-1:0] we,
  input  logic [15:0]          addr,
  input  logic [15:0]          wdata,
  output logic [N_CLIENTS-1:0] done,
  output logic                 err,
  output logic [DATA_W-1:0]    rdata,
  output logic                 busy,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_we,
  output logic [ADDR_W-1:0]    cmd_addr,
  output logic [DATA_W-1:0]    cmd_wdata,
  input  logic                 rsp_valid,
  input  logic                 rsp_nack,
  input  logic [DATA_W-1:0]    rsp_rdata
);

  localparam int CW = gap_cnt_w(WR_GAP_CYC);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);
  localparam logic [CW-1:0] GAP_LD = CW'(WR_GAP_CYC);

  arb_state_e state, state_nxt;

  logic              owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RW-1:0]     retry_cnt;
  logic [CW-1:0]     gap_cnt;
  logic [1:0]        done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic gnt_idx;
  logic grant;
  logic retry;
  logic fin;
  logic fin_err;
  logic load_gap;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .upd     (grant),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    retry     = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    load_gap  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready)
          state_nxt = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          if (!rsp_nack) begin
            fin = 1'b1;
            if (we_q) begin
              load_gap  = 1'b1;
              state_nxt = ST_GAP;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else if (retry_cnt < MAX_R) begin
            retry     = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            fin       = 1'b1;
            fin_err   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // Leaving on 1 makes GAP last exactly WR_GAP_CYC cycles.
        if (gap_cnt <= CW'(1))
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      if (grant) begin
        owner     <= gnt_idx;
        we_q      <= we[gnt_idx];
        addr_q    <= gnt_idx ? addr[15:8] : addr[7:0];
        wdata_q   <= gnt_idx ? wdata[15:8] : wdata[7:0];
        retry_cnt <= '0;
      end
      if (retry)
        retry_cnt <= retry_cnt + 1'b1;
      if (fin) begin
        done_q <= owner ? 2'b10 : 2'b01;
        err_q  <= fin_err;
        if (!fin_err && !we_q)
          rdata_q <= rsp_rdata;
      end
      if (load_gap)
        gap_cnt <= GAP_LD;
      else if (state == ST_GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = (state != ST_IDLE);
  assign cmd_valid = (state == ST_ISSUE);
  assign cmd_we    = we_q;
  assign cmd_addr  = addr_q;
  assign cmd_wdata = wdata_q;

endmodule
